// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source side of a req/ack CDC handshake, two- or four-phase, ack brought in through an NSYNC-flop synchronizer.
module cdc_handshake_tx #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned NSYNC      = 2,
  parameter bit          FOUR_PHASE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_req,
  input  logic             i_ack_async,
  output logic             o_done
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_REL} state_t;
  state_t           state;
  logic [NSYNC-1:0] sync;
  logic             ack_s;
  assign ack_s = sync[NSYNC-1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= '0;
    else        sync <= {sync[NSYNC-2:0], i_ack_async};
  // In four-phase WAIT_ACK o_req is 1, so ack_s == o_req covers both protocols.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      o_ready <= 1'b1;
      o_req   <= 1'b0;
      o_data  <= '0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: if (i_valid && o_ready) begin
          o_data  <= i_data;
          o_ready <= 1'b0;
          state   <= LAUNCH;
        end
        LAUNCH: begin
          o_req <= FOUR_PHASE ? 1'b1 : ~o_req;
          state <= WAIT_ACK;
        end
        WAIT_ACK: if (ack_s == o_req) begin
          if (FOUR_PHASE) begin
            o_req <= 1'b0;
            state <= WAIT_REL;
          end else begin
            o_ready <= 1'b1;
            o_done  <= 1'b1;
            state   <= IDLE;
          end
        end
        WAIT_REL: if (!ack_s) begin
          o_ready <= 1'b1;
          o_done  <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb_cdc_handshake_tx: directed vectors on two- and four-phase instances; a monitor checks o_data against a queue on every o_done.
module tb_cdc_handshake_tx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       valid2 = 1'b0, valid4 = 1'b0;
  logic [7:0] din2 = '0, din4 = '0;
  logic       rdy2, rdy4, req2, req4, done2, done4, ack2, ack4;
  logic [7:0] dout2, dout4;
  logic       loop2 = 1'b1, ack2_force = 1'b0;
  logic [7:0] q2[$], q4[$];
  int         vectors = 0, miscompares = 0;
  logic [9:0] t2_req = 10'b0000111110, t2_rdy = 10'b1000010000;
  logic [7:0] t4_req = 8'b00001110,    t4_rdy = 8'b10000000;

  always #5 clk = ~clk;
  assign ack2 = loop2 ? req2 : ack2_force;
  assign ack4 = req4;

  cdc_handshake_tx #(.WIDTH(8), .NSYNC(2), .FOUR_PHASE(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_valid(valid2), .o_ready(rdy2), .i_data(din2),
    .o_data(dout2), .o_req(req2), .i_ack_async(ack2), .o_done(done2));
  cdc_handshake_tx #(.WIDTH(8), .NSYNC(2), .FOUR_PHASE(1'b1)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_valid(valid4), .o_ready(rdy4), .i_data(din4),
    .o_data(dout4), .o_req(req4), .i_ack_async(ack4), .o_done(done4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every completion must match the oldest word issued.
  always @(negedge clk)
    if (rst_n) begin
      if (done2) begin
        if (q2.size() == 0) chk("done2_spurious", done2, 0);
        else chk("done2_data", dout2, q2.pop_front());
      end
      if (done4) begin
        if (q4.size() == 0) chk("done4_spurious", done4, 0);
        else chk("done4_data", dout4, q4.pop_front());
      end
    end

  initial begin
    #3 rst_n = 1'b0;
    #1;
    chk("rst_ready", rdy2, 1);
    chk("rst_req", req2, 0);
    chk("rst_data", dout2, 0);
    chk("rst_done", done2, 0);
    chk("rst_ready4", rdy4, 1);
    #8 rst_n = 1'b1;
    // Two-phase back-to-back: 0xA5 accepted at edge 0, 0x3C at edge 5.
    valid2 = 1'b1; din2 = 8'hA5; q2.push_back(8'hA5);
    for (int e = 0; e < 10; e++) begin
      edge1();
      if (e == 0) begin din2 = 8'h3C; q2.push_back(8'h3C); end
      if (e == 5) valid2 = 1'b0;
      chk($sformatf("p2_req_e%0d", e), req2, t2_req[e]);
      chk($sformatf("p2_rdy_e%0d", e), rdy2, t2_rdy[e]);
      chk($sformatf("p2_done_e%0d", e), done2, t2_rdy[e]);
      chk($sformatf("p2_data_e%0d", e), dout2, e < 5 ? 8'hA5 : 8'h3C);
    end
    // Busy: a word offered during WAIT_ACK waits for o_ready.
    valid2 = 1'b1; din2 = 8'h11; q2.push_back(8'h11);
    edge1();
    valid2 = 1'b0;
    edge1();
    valid2 = 1'b1; din2 = 8'hFF; q2.push_back(8'hFF);
    for (int e = 2; e < 5; e++) begin
      edge1();
      chk($sformatf("busy_data_e%0d", e), dout2, 8'h11);
      chk($sformatf("busy_req_e%0d", e), req2, 1);
    end
    edge1();
    valid2 = 1'b0;
    chk("busy_accept_ff", dout2, 8'hFF);
    chk("busy_accept_rdy", rdy2, 0);
    repeat (4) edge1();
    chk("busy_ff_done_rdy", rdy2, 1);
    chk("busy_ff_req", req2, 0);
    // Stall: ack held at 0 while a request is outstanding.
    loop2 = 1'b0; ack2_force = 1'b0;
    valid2 = 1'b1; din2 = 8'h77; q2.push_back(8'h77);
    edge1();
    valid2 = 1'b0;
    repeat (50) edge1();
    chk("stall_ready", rdy2, 0);
    chk("stall_req", req2, 1);
    chk("stall_data", dout2, 8'h77);
    // Reset mid-handshake abandons the word.
    #2 rst_n = 1'b0;
    #1;
    q2.delete();
    chk("mid_rst_ready", rdy2, 1);
    chk("mid_rst_req", req2, 0);
    chk("mid_rst_data", dout2, 0);
    chk("mid_rst_done", done2, 0);
    @(negedge clk) rst_n = 1'b1;
    // Spurious ack toggles in IDLE.
    for (int i = 0; i < 8; i++) begin
      edge1();
      ack2_force = ~ack2_force;
      chk($sformatf("idle_ack_rdy_%0d", i), rdy2, 1);
      chk($sformatf("idle_ack_req_%0d", i), req2, 0);
    end
    ack2_force = 1'b0;
    repeat (3) edge1();
    loop2 = 1'b1;
    valid2 = 1'b1; din2 = 8'h42; q2.push_back(8'h42);
    edge1();
    valid2 = 1'b0;
    chk("post_rst_accept", dout2, 8'h42);
    begin
      int n = 0;
      while (!rdy2 && n < 20) begin edge1(); n++; end
    end
    chk("post_rst_complete", rdy2, 1);
    chk("post_rst_req", req2, 1);
    // Four-phase: 0x5A accepted at edge 0.
    valid4 = 1'b1; din4 = 8'h5A; q4.push_back(8'h5A);
    for (int e = 0; e < 8; e++) begin
      edge1();
      if (e == 0) valid4 = 1'b0;
      chk($sformatf("p4_req_e%0d", e), req4, t4_req[e]);
      chk($sformatf("p4_rdy_e%0d", e), rdy4, t4_rdy[e]);
      chk($sformatf("p4_done_e%0d", e), done4, t4_rdy[e]);
      chk($sformatf("p4_data_e%0d", e), dout4, 8'h5A);
    end
    repeat (3) edge1();
    chk("q2_drained", q2.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
